// File: rtl/reset_sequencer.sv
// Reset sequencer: stretches PLL-lock and button resets into a
// clean registered SoC reset with a reboot counter.
module reset_sequencer #(
  parameter int HOLD_CYCLES = 16
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic       button_in,
  output logic       reset_out,
  output logic       ready_out,
  output logic [7:0] reboot_count_out
);

  localparam int CNT_W =
    ($clog2(HOLD_CYCLES) < 1) ? 1 : $clog2(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ASSERT = 2'd0,
    COUNT  = 2'd1,
    RUN    = 2'd2
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_n;
  logic             bump;
  logic             btn_s1;
  logic             btn_s2;
  logic             btn;

  assign btn = btn_s2;

  // Two-flop synchronizer for the raw button.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      btn_s1 <= button_in;
      btn_s2 <= btn_s1;
    end
  end

  // Next state, next hold count and reboot strobe.
  always_comb begin
    state_n = state;
    count_n = count;
    bump    = 1'b0;
    unique case (state)
      ASSERT: begin
        count_n = '0;
        if (!btn) state_n = COUNT;
      end
      COUNT: begin
        if (btn) begin
          state_n = ASSERT;
          count_n = '0;
        end else if (count == LAST) begin
          state_n = RUN;
          count_n = '0;
        end else begin
          count_n = count + CNT_W'(1);
        end
      end
      RUN: begin
        count_n = '0;
        if (btn) begin
          state_n = ASSERT;
          bump    = 1'b1;
        end
      end
      default: begin
        state_n = ASSERT;
        count_n = '0;
      end
    endcase
  end

  // State, counter and outputs share one edge so reset_out
  // flips on the same edge that enters or leaves RUN.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state     <= ASSERT;
      count     <= '0;
      reset_out <= 1'b0;
      ready_out <= 1'b0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      reset_out <= (state_n == RUN);
      ready_out <= (state_n == RUN);
    end
  end

  // Saturating count of button-initiated reboots.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      reboot_count_out <= 8'd0;
    end else if (bump && reboot_count_out != 8'hFF) begin
      reboot_count_out <= reboot_count_out + 8'd1;
    end
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 The module SHALL have parameter HOLD_CYCLES, default 16, giving the number of clock cycles reset_out is held low after all reset sources clear; legal range 2..65535.
REQ-002 The module SHALL derive counter width CNT_W = $clog2(HOLD_CYCLES) (minimum 1) from HOLD_CYCLES.
REQ-003 Port clk_in, input, 1 bit: the single system clock (slow PLL clock domain).
REQ-004 Port reset_in, input, 1 bit: asynchronous, active-low reset (PLL locked indication); low forces the block into reset immediately.
REQ-005 Port button_in, input, 1 bit: raw reset button, active-high, asynchronous to clk_in.
REQ-006 Port reset_out, output, 1 bit: registered active-low reset to the SoC; 0 = SoC held in reset.
REQ-007 Port ready_out, output, 1 bit: registered, 1 exactly when the FSM is in RUN.
REQ-008 Port reboot_count_out, output, 8 bits: number of button-initiated resets since reset_in deassertion, saturating.

Function
REQ-009 button_in SHALL pass through a two-flop synchronizer (btn_s1, btn_s2); only btn_s2 ("btn") SHALL be used by the FSM.
REQ-010 The FSM SHALL have three states: ASSERT, COUNT, RUN.
REQ-011 ASSERT: reset_out=0, counter=0; btn=1 -> stay; btn=0 -> COUNT.
REQ-012 COUNT: reset_out=0; btn=1 -> ASSERT with counter cleared; else counter==HOLD_CYCLES-1 -> RUN; else counter increments by 1.
REQ-013 RUN: reset_out=1, ready_out=1, counter held at 0; btn=1 -> ASSERT and reboot_count_out increments.
REQ-014 reset_out and ready_out SHALL be driven from flops updated on the same edge as the state register, so reset_out changes on the edge that enters or leaves RUN, with no combinational path from any input.
REQ-015 With button idle, reset_out SHALL rise on the (HOLD_CYCLES+1)th rising edge of clk_in after reset_in deasserts.
REQ-016 From RUN, a button_in level sampled high on edge N SHALL drive reset_out low on edge N+2.
REQ-017 The button SHALL be level-sensitive: while btn stays 1, the FSM SHALL remain in ASSERT and the hold count SHALL NOT start.
REQ-018 A btn=1 pulse of any length >=1 synchronized cycle in COUNT SHALL restart the full HOLD_CYCLES hold.
REQ-019 reboot_count_out SHALL increment only on a RUN->ASSERT transition; at 255 it SHALL stay 255.
REQ-020 The counter SHALL never exceed HOLD_CYCLES-1 and SHALL never wrap.

Reset
REQ-021 reset_in low SHALL asynchronously set: state=ASSERT, counter=0, btn_s1=btn_s2=0, reset_out=0, ready_out=0, reboot_count_out=0.
REQ-022 reset_in asserted mid-COUNT or in RUN SHALL drop reset_out to 0 without waiting for a clock edge.
REQ-023 Deassertion of reset_in SHALL be treated as synchronous to clk_in; the first post-release edge evaluates ASSERT normally.

Verification
REQ-024 HOLD_CYCLES=16, button idle, release reset_in -> reset_out=0 through edge 16, reset_out=1 and ready_out=1 after edge 17, reboot_count_out=0.
REQ-025 In RUN, button_in high for 1 cycle at edge N -> reset_out=0 after edge N+2, reboot_count_out=1, reset_out=1 again 17 edges after btn returns to 0.
REQ-026 In COUNT with counter=10, 1-cycle btn pulse -> ASSERT, counter=0, full 16-cycle hold restarts, reboot_count_out unchanged.
REQ-027 Hold button_in high 100 cycles from RUN -> reset_out stays 0 for the whole press plus 17 edges after release; reboot_count_out increments by exactly 1.
REQ-028 Drive reset_in low mid-COUNT and separately in RUN, between clock edges -> all outputs 0 immediately, before the next edge.
REQ-029 Issue 300 button presses from RUN -> reboot_count_out saturates at 255 and remains 255.
